// File: rtl/otdr_pulse_scheduler.sv
// OTDR pulse scheduler: runs a burst of laser shots on a fixed period and,
// optionally, an ADC acquisition window at a programmable offset in each shot.
// Optional feature macro: OTDR_PULSE_SCHED_ACQ_EN. When it is defined, the
// acquisition-window logic is built. When it is not defined, acq_window is
// held at 0 and cfg_acq_delay / cfg_acq_len are ignored.
module otdr_pulse_scheduler #(
    parameter int CNT_W  = 32,
    parameter int SHOT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_pulse_width,
    input  logic [CNT_W-1:0]  cfg_acq_delay,
    input  logic [CNT_W-1:0]  cfg_acq_len,
    input  logic [SHOT_W-1:0] cfg_shots,
    output logic              laser_pulse,
    output logic              acq_window,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [SHOT_W-1:0] shot_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  p_q, p_d;
    logic [SHOT_W-1:0] shot_q, shot_d;

    // Config captured at start; later changes on cfg_* have no effect on a burst.
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  width_q, width_d;
    logic [SHOT_W-1:0] shots_q, shots_d;

    logic              laser_q, laser_d;
    logic              acq_q, acq_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;

    logic              cfg_valid;

`ifdef OTDR_PULSE_SCHED_ACQ_EN
    logic [CNT_W-1:0]  delay_q, delay_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W:0]    acq_end;
`else
    logic              unused_acq_cfg;
    assign unused_acq_cfg = ^{cfg_acq_delay, cfg_acq_len};
`endif

    assign cfg_valid = (cfg_period >= CNT_W'(2)) &&
                       (cfg_pulse_width != '0) &&
                       (cfg_pulse_width < cfg_period) &&
                       (cfg_shots != '0);

    // Next-state logic: burst sequencing, phase/shot counters, config capture.
    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        shot_d    = shot_q;
        period_d  = period_q;
        width_d   = width_q;
        shots_d   = shots_q;
        cfg_err_d = 1'b0;
`ifdef OTDR_PULSE_SCHED_ACQ_EN
        delay_d   = delay_q;
        len_d     = len_q;
`endif
        case (state_q)
            IDLE: begin
                // abort outranks start even while idle
                if (start && !abort) begin
                    if (cfg_valid) begin
                        state_d  = RUN;
                        p_d      = '0;
                        shot_d   = '0;
                        period_d = cfg_period;
                        width_d  = cfg_pulse_width;
                        shots_d  = cfg_shots;
`ifdef OTDR_PULSE_SCHED_ACQ_EN
                        delay_d  = cfg_acq_delay;
                        len_d    = cfg_acq_len;
`endif
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    p_d     = '0;
                end else if (p_q == period_q - CNT_W'(1)) begin
                    p_d = '0;
                    if (shot_q == shots_q - SHOT_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        shot_d = shot_q + SHOT_W'(1);
                    end
                end else begin
                    p_d = p_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                p_d     = '0;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up
    // with the state/phase they describe.
`ifdef OTDR_PULSE_SCHED_ACQ_EN
    // One extra bit keeps delay+len from wrapping; p < period clips the window.
    assign acq_end = {1'b0, delay_d} + {1'b0, len_d};
`endif

    always_comb begin
        laser_d = (state_d == RUN) && (p_d < width_d);
`ifdef OTDR_PULSE_SCHED_ACQ_EN
        acq_d   = (state_d == RUN) && (p_d >= delay_d) && ({1'b0, p_d} < acq_end);
`else
        acq_d   = 1'b0;
`endif
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    // State, counter, config and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            p_q       <= '0;
            shot_q    <= '0;
            period_q  <= '0;
            width_q   <= '0;
            shots_q   <= '0;
            laser_q   <= 1'b0;
            acq_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
`ifdef OTDR_PULSE_SCHED_ACQ_EN
            delay_q   <= '0;
            len_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            shot_q    <= shot_d;
            period_q  <= period_d;
            width_q   <= width_d;
            shots_q   <= shots_d;
            laser_q   <= laser_d;
            acq_q     <= acq_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
`ifdef OTDR_PULSE_SCHED_ACQ_EN
            delay_q   <= delay_d;
            len_q     <= len_d;
`endif
        end
    end

    assign laser_pulse = laser_q;
    assign acq_window  = acq_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cfg_err     = cfg_err_q;
    assign shot_idx    = shot_q;

endmodule

// File: tb/tb_otdr_pulse_scheduler.sv
// Testbench for otdr_pulse_scheduler: table of burst configurations with
// hand-computed results, plus directed sequences for abort, reset, and start
// arbitration corner cases.
module tb_otdr_pulse_scheduler;

`ifdef OTDR_PULSE_SCHED_ACQ_EN
    localparam bit ACQ_EN = 1'b1;
`else
    localparam bit ACQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [31:0] cfg_period, cfg_pulse_width, cfg_acq_delay, cfg_acq_len;
    logic [15:0] cfg_shots;
    logic        laser_pulse, acq_window, busy, done, cfg_err;
    logic [15:0] shot_idx;

    int checks = 0;
    int errors = 0;

    otdr_pulse_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .cfg_period      (cfg_period),
        .cfg_pulse_width (cfg_pulse_width),
        .cfg_acq_delay   (cfg_acq_delay),
        .cfg_acq_len     (cfg_acq_len),
        .cfg_shots       (cfg_shots),
        .laser_pulse     (laser_pulse),
        .acq_window      (acq_window),
        .busy            (busy),
        .done            (done),
        .cfg_err         (cfg_err),
        .shot_idx        (shot_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] period;
        logic [31:0] width;
        logic [15:0] shots;
        logic [31:0] delay;
        logic [31:0] len;
        bit          ok;         // config expected to be accepted
        int          done_cyc;   // cycle (after start sample) where done is high
        int          laser_cnt;  // total laser-high cycles in the burst
        int          acq_cnt;    // total acq-high cycles with the window built in
        logic [15:0] last_idx;   // shot_idx after the burst
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [31:0] p, input logic [31:0] w, input logic [15:0] s,
                           input logic [31:0] d, input logic [31:0] l);
        cfg_period      = p;
        cfg_pulse_width = w;
        cfg_shots       = s;
        cfg_acq_delay   = d;
        cfg_acq_len     = l;
    endtask

    logic [15:0] prev_idx;

    task automatic run_vec(input int vi);
        vec_t   v;
        int     lcnt, acnt, last;
        longint ph, sh;
        bit     in_run, e_acq;
        v = vecs[vi];
        lcnt = 0;
        acnt = 0;
        set_cfg(v.period, v.width, v.shots, v.delay, v.len);
        start = 1'b1;
        last = v.ok ? v.done_cyc + 2 : 3;
        for (int k = 1; k <= last; k++) begin
            tick();
            start = 1'b0;
            if (v.ok) begin
                in_run = (k < v.done_cyc);
                ph = longint'(k - 1) % longint'(v.period);
                sh = longint'(k - 1) / longint'(v.period);
                e_acq = ACQ_EN && in_run && (ph >= longint'(v.delay)) &&
                        (ph < longint'(v.delay) + longint'(v.len));
                chk($sformatf("v%0d_k%0d_laser", vi, k), laser_pulse,
                    in_run && (ph < longint'(v.width)));
                chk($sformatf("v%0d_k%0d_acq", vi, k), acq_window, e_acq);
                chk($sformatf("v%0d_k%0d_busy", vi, k), busy, k <= v.done_cyc);
                chk($sformatf("v%0d_k%0d_done", vi, k), done, k == v.done_cyc);
                chk($sformatf("v%0d_k%0d_err", vi, k), cfg_err, 0);
                chk($sformatf("v%0d_k%0d_idx", vi, k), shot_idx, in_run ? sh : longint'(v.last_idx));
            end else begin
                chk($sformatf("v%0d_k%0d_err", vi, k), cfg_err, k == 1);
                chk($sformatf("v%0d_k%0d_busy", vi, k), busy, 0);
                chk($sformatf("v%0d_k%0d_laser", vi, k), laser_pulse, 0);
                chk($sformatf("v%0d_k%0d_idx", vi, k), shot_idx, prev_idx);
            end
            lcnt += int'(laser_pulse);
            acnt += int'(acq_window);
        end
        chk($sformatf("v%0d_laser_cnt", vi), lcnt, v.ok ? v.laser_cnt : 0);
        chk($sformatf("v%0d_acq_cnt", vi), acnt, (v.ok && ACQ_EN) ? v.acq_cnt : 0);
        if (v.ok) prev_idx = v.last_idx;
        $display("vec %0d period=%0d width=%0d shots=%0d delay=%0d len=%0d laser=%0d acq=%0d",
                 vi, v.period, v.width, v.shots, v.delay, v.len, lcnt, acnt);
    endtask

    int saw_done, saw_err, lcnt2, done_at, saw_busy;

    initial begin
        //          period width shots delay len        ok done laser acq idx
        vecs[0] = '{32'd10, 32'd3, 16'd2, 32'd4, 32'd4,          1'b1, 21, 6, 8, 16'd1};
        vecs[1] = '{32'd5,  32'd5, 16'd1, 32'd0, 32'd0,          1'b0, 0,  0, 0, 16'd0};
        vecs[2] = '{32'd5,  32'd5, 16'd0, 32'd0, 32'd0,          1'b0, 0,  0, 0, 16'd0};
        vecs[3] = '{32'd6,  32'd1, 16'd3, 32'd4, 32'd10,         1'b1, 19, 3, 6, 16'd2};
        vecs[4] = '{32'd2,  32'd1, 16'd1, 32'd0, 32'd0,          1'b1, 3,  1, 0, 16'd0};
        vecs[5] = '{32'd1,  32'd1, 16'd1, 32'd0, 32'd0,          1'b0, 0,  0, 0, 16'd0};
        vecs[6] = '{32'd4,  32'd0, 16'd1, 32'd0, 32'd0,          1'b0, 0,  0, 0, 16'd0};
        vecs[7] = '{32'd4,  32'd3, 16'd2, 32'd4, 32'd3,          1'b1, 9,  6, 0, 16'd1};
        vecs[8] = '{32'd5,  32'd1, 16'd1, 32'd2, 32'hFFFF_FFFF,  1'b1, 6,  1, 3, 16'd0};

        rst = 1'b1;
        start = 1'b1;
        abort = 1'b0;
        set_cfg(32'd10, 32'd3, 16'd2, 32'd4, 32'd4);
        tick();
        tick();
        tick();
        start = 1'b0;
        chk("rst_laser", laser_pulse, 0);
        chk("rst_acq", acq_window, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_idx", shot_idx, 0);
        $display("reset state laser=%0b acq=%0b busy=%0b done=%0b err=%0b idx=%0d",
                 laser_pulse, acq_window, busy, done, cfg_err, shot_idx);
        rst = 1'b0;
        tick();
        prev_idx = 16'd0;

        for (int i = 0; i < 9; i++) run_vec(i);

        // Abort mid-burst: period 8, width 2, 4 shots, abort sampled at cycle 12.
        set_cfg(32'd8, 32'd2, 16'd4, 32'd0, 32'd0);
        start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            start = 1'b0;
        end
        chk("abort_pre_busy", busy, 1);
        chk("abort_pre_idx", shot_idx, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_laser", laser_pulse, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_idx", shot_idx, 1);
        saw_done = 0;
        saw_busy = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            saw_done += int'(done);
            saw_busy += int'(busy);
        end
        chk("abort_no_done", saw_done, 0);
        chk("abort_stays_idle", saw_busy, 0);
        $display("abort seq idx=%0d done_seen=%0d", shot_idx, saw_done);

        // start while busy (with bad config and changed cfg_* inputs) is ignored.
        set_cfg(32'd10, 32'd3, 16'd2, 32'd4, 32'd4);
        start = 1'b1;
        saw_err = 0;
        lcnt2 = 0;
        done_at = 0;
        for (int k = 1; k <= 25; k++) begin
            tick();
            start = 1'b0;
            if (k == 5) begin
                start = 1'b1;
                set_cfg(32'd3, 32'd3, 16'd0, 32'd0, 32'd0);
            end
            saw_err += int'(cfg_err);
            lcnt2 += int'(laser_pulse);
            if (done && done_at == 0) done_at = k;
        end
        chk("busy_start_no_err", saw_err, 0);
        chk("busy_start_done_cyc", done_at, 21);
        chk("busy_start_laser_cnt", lcnt2, 6);
        $display("start-while-busy done_at=%0d laser=%0d err=%0d", done_at, lcnt2, saw_err);

        // start and abort together in IDLE: abort wins, valid or not.
        set_cfg(32'd10, 32'd3, 16'd2, 32'd4, 32'd4);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", busy, 0);
        chk("sa_err", cfg_err, 0);
        tick();
        chk("sa_laser", laser_pulse, 0);
        set_cfg(32'd5, 32'd5, 16'd1, 32'd0, 32'd0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_bad_err", cfg_err, 0);
        $display("start+abort idle busy=%0b err=%0b", busy, cfg_err);

        // Reset mid-burst at p=3 of shot 2, then restart immediately.
        set_cfg(32'd8, 32'd2, 16'd4, 32'd0, 32'd0);
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            start = 1'b0;
        end
        chk("rstmid_pre_idx", shot_idx, 2);
        chk("rstmid_pre_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_laser", laser_pulse, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        chk("rstmid_err", cfg_err, 0);
        chk("rstmid_idx", shot_idx, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_laser", laser_pulse, 1);
        chk("restart_busy", busy, 1);
        chk("restart_idx", shot_idx, 0);
        $display("reset mid-burst restart laser=%0b idx=%0d", laser_pulse, shot_idx);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/otdr_pulse_scheduler.md
OTDR_PULSE_SCHEDULER -- requirements
Module: otdr_pulse_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of period, pulse-width and acquisition counters/config fields.
REQ-002 SHALL have parameter SHOT_W, default 16: width of the shot-count config field and the shot index.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a burst.
REQ-006 SHALL have port abort, input, 1: terminate the burst immediately.
REQ-007 SHALL have port cfg_period, input, CNT_W: shot period in clk cycles.
REQ-008 SHALL have port cfg_pulse_width, input, CNT_W: laser pulse high time in cycles.
REQ-009 SHALL have port cfg_acq_delay, input, CNT_W: acquisition window start offset within the period.
REQ-010 SHALL have port cfg_acq_len, input, CNT_W: acquisition window length.
REQ-011 SHALL have port cfg_shots, input, SHOT_W: number of shots per burst.
REQ-012 SHALL have port laser_pulse, output, 1: laser trigger, registered.
REQ-013 SHALL have port acq_window, output, 1: ADC capture enable, registered.
REQ-014 SHALL have port busy, output, 1: high while a burst runs.
REQ-015 SHALL have port done, output, 1: one-cycle pulse at normal burst completion.
REQ-016 SHALL have port cfg_err, output, 1: one-cycle pulse when start is rejected.
REQ-017 SHALL have port shot_idx, output, SHOT_W: index of the current shot, 0-based.

Function
REQ-018 SHALL implement states IDLE, RUN, DONE.
REQ-019 In IDLE, start=1 with valid config SHALL latch all cfg_* inputs and enter RUN next cycle; cfg_* changes during RUN SHALL be ignored.
REQ-020 Config SHALL be valid iff cfg_period>=2, 1<=cfg_pulse_width<cfg_period, and cfg_shots>=1.
REQ-021 Invalid config on start SHALL pulse cfg_err for one cycle and keep the block in IDLE.
REQ-022 In RUN, phase counter p SHALL run 0..period-1 and then wrap to 0, incrementing shot_idx on wrap.
REQ-023 laser_pulse SHALL be 1 exactly when RUN and p<pulse_width; first high cycle is the cycle after start is sampled.
REQ-024 acq_window SHALL be 1 exactly when RUN and acq_delay<=p<acq_delay+acq_len; the sum SHALL be computed at CNT_W+1 bits (no wrap); acq_len=0 or acq_delay>=period gives no window; the window SHALL clip at period-1.
REQ-025 When p=period-1 and shot_idx=shots-1, the block SHALL enter DONE; DONE SHALL assert done for one cycle, then return to IDLE.
REQ-026 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-027 abort=1 in RUN or DONE SHALL force IDLE next cycle with laser_pulse, acq_window and busy at 0, and SHALL NOT pulse done.
REQ-028 start while busy SHALL be ignored, with no cfg_err.
REQ-029 start and abort both high in IDLE: abort SHALL win; no burst, no cfg_err.
REQ-030 shot_idx SHALL hold its last value in IDLE until the next accepted start, which clears it to 0.

Reset
REQ-031 rst=1 SHALL force IDLE, p=0, shot_idx=0, and laser_pulse=acq_window=busy=done=cfg_err=0 on the next edge, overriding all other inputs, including mid-burst.
REQ-032 Latched config registers SHALL reset to 0.

Configuration
REQ-033 Macro OTDR_PULSE_SCHED_ACQ_EN defined SHALL compile in the acquisition-window logic per REQ-024.
REQ-034 Without OTDR_PULSE_SCHED_ACQ_EN, acq_window SHALL be constant 0, cfg_acq_delay and cfg_acq_len SHALL be unused, and all other behaviour SHALL be unchanged.

Verification
REQ-035 period=10, width=3, shots=2, acq_delay=4, acq_len=4, start at cycle 0 -> laser high at cycles 1-3 and 11-13; acq high at 5-8 and 15-18; done at 21; busy at 1-21.
REQ-036 period=5, width=5, shots=1 -> cfg_err one cycle, busy stays 0; repeat with shots=0 -> same response.
REQ-037 period=8, width=2, shots=4, abort at cycle 12 -> laser/busy 0 from cycle 13, done never asserts, shot_idx=1.
REQ-038 period=6, width=1, acq_delay=4, acq_len=10 -> acq high at p=4..5 only, every shot; with macro undefined -> acq_window always 0.
REQ-039 rst mid-burst at p=3, shot 2 -> all outputs 0 next cycle; start next cycle -> shot_idx=0, laser high the following cycle.
